// File: rtl/rgb_seq_if.sv
// Control/status bundle between the debounced button front end and the RGB pattern sequencer.
interface rgb_seq_if #(
    parameter int PWM_BITS = 4
);
    logic                step_fwd;
    logic                step_back;
    logic                mode_toggle;
    logic [PWM_BITS-1:0] brightness;
    logic [2:0]          rgb;
    logic [2:0]          step;
    logic                auto_mode;

    modport master (
        output step_fwd, step_back, mode_toggle, brightness,
        input  rgb, step, auto_mode
    );

    modport slave (
        input  step_fwd, step_back, mode_toggle, brightness,
        output rgb, step, auto_mode
    );
endinterface

// File: rtl/rgb_pattern_sequencer.sv
// Steps an RGB LED through a fixed colour pattern, manually or on a dwell timer,
// with PWM brightness and selectable output polarity.
module rgb_pattern_sequencer #(
    parameter int N_STEPS      = 6,
    parameter int DWELL_CYCLES = 12000000,
    parameter int PWM_BITS     = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    rgb_seq_if.slave bus
);
    localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [2:0]          LAST_STEP  = 3'(N_STEPS - 1);
    localparam logic [2:0]          UNLIT      = ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    mode_t               r_mode;
    mode_t               w_mode_next;
    logic [2:0]          r_step;
    logic [2:0]          w_step_next;
    logic [2:0]          w_step_inc;
    logic [2:0]          w_step_dec;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  w_dwell_next;
    logic [PWM_BITS-1:0] r_pwm;
    logic [PWM_BITS-1:0] w_pwm_next;
    logic [2:0]          r_rgb;
    logic [2:0]          w_rgb_next;
    logic [2:0]          w_colour;
    logic                w_manual;
    logic                w_expiry;
    logic                w_illegal;
    logic                w_lit_en;

    assign w_step_inc = (r_step == LAST_STEP) ? 3'd0 : r_step + 3'd1;
    assign w_step_dec = (r_step == 3'd0) ? LAST_STEP : r_step - 3'd1;
    assign w_manual   = bus.step_fwd | bus.step_back;
    assign w_expiry   = (r_mode == AUTO) && (r_dwell == DWELL_LAST);
    assign w_illegal  = (32'(r_step) >= N_STEPS);
    assign w_lit_en   = (r_pwm < bus.brightness);
    assign w_pwm_next = (r_pwm == PWM_LAST) ? '0 : r_pwm + 1'b1;

    always_comb begin
        w_mode_next = r_mode;
        if (bus.mode_toggle) begin
            w_mode_next = (r_mode == MANUAL) ? AUTO : MANUAL;
        end

        w_step_next = r_step;
        if (w_illegal) begin
            w_step_next = 3'd0;
        end else if (bus.step_fwd && bus.step_back) begin
            w_step_next = r_step;
        end else if (bus.step_fwd) begin
            w_step_next = w_step_inc;
        end else if (bus.step_back) begin
            w_step_next = w_step_dec;
        end else if (w_expiry) begin
            w_step_next = w_step_inc;
        end

        // Any manual event, expiry, or mode change restarts the dwell from zero.
        w_dwell_next = '0;
        if ((r_mode == AUTO) && (w_mode_next == AUTO) && !w_manual && !w_expiry) begin
            w_dwell_next = r_dwell + 1'b1;
        end
    end

    always_comb begin
        w_colour = 3'b000;
        case (r_step)
            3'd0:    w_colour = 3'b100;
            3'd1:    w_colour = 3'b010;
            3'd2:    w_colour = 3'b001;
            3'd3:    w_colour = 3'b110;
            3'd4:    w_colour = 3'b011;
            3'd5:    w_colour = 3'b101;
            3'd6:    w_colour = 3'b111;
            default: w_colour = 3'b000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign w_rgb_next[gi] = (w_colour[gi] & w_lit_en & ~w_illegal) ^ UNLIT[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MANUAL;
            r_step  <= 3'd0;
            r_dwell <= '0;
            r_pwm   <= '0;
            r_rgb   <= UNLIT;
        end else begin
            r_mode  <= w_mode_next;
            r_step  <= w_step_next;
            r_dwell <= w_dwell_next;
            r_pwm   <= w_pwm_next;
            r_rgb   <= w_rgb_next;
        end
    end

    assign bus.rgb       = r_rgb;
    assign bus.step      = r_step;
    assign bus.auto_mode = (r_mode == AUTO);
endmodule

// File: tb/tb_rgb_pattern_sequencer.sv
// Directed bench: dut_a is active-low 4-bit PWM, dut_b is active-high 3-bit PWM; both dwell 10.
module tb_rgb_pattern_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_seq_if #(.PWM_BITS(4)) bus_a ();
    rgb_seq_if #(.PWM_BITS(3)) bus_b ();

    rgb_pattern_sequencer #(
        .N_STEPS(6), .DWELL_CYCLES(10), .PWM_BITS(4), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    rgb_pattern_sequencer #(
        .N_STEPS(6), .DWELL_CYCLES(10), .PWM_BITS(3), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Logical colours of steps 0..5, lit = 1.
    logic [2:0] lit_tab [6] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101};

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic fwd, input logic back, input logic tog);
        bus_a.step_fwd    = fwd;
        bus_a.step_back   = back;
        bus_a.mode_toggle = tog;
        tick();
        bus_a.step_fwd    = 1'b0;
        bus_a.step_back   = 1'b0;
        bus_a.mode_toggle = 1'b0;
    endtask

    // Edges until dut_a.step changes; limit+1 means it never changed.
    task automatic wait_step_change(input int limit, output int n);
        logic [2:0] prev;
        prev = bus_a.step;
        n = limit + 1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (bus_a.step != prev) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_b(input int cycles, output int n_red, output int n_dark);
        n_red  = 0;
        n_dark = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus_b.rgb == 3'b100) n_red++;
            if (bus_b.rgb == 3'b000) n_dark++;
        end
    endtask

    initial begin
        int n;
        int n_red;
        int n_dark;
        int moves;

        rst = 1'b1;
        bus_a.step_fwd = 1'b0; bus_a.step_back = 1'b0; bus_a.mode_toggle = 1'b0;
        bus_a.brightness = 4'hF;
        bus_b.step_fwd = 1'b0; bus_b.step_back = 1'b0; bus_b.mode_toggle = 1'b0;
        bus_b.brightness = 3'd0;

        // Reset state
        tick();
        tick();
        expect_eq("rst_rgb_a", 32'(bus_a.rgb), 32'b111);
        expect_eq("rst_rgb_b", 32'(bus_b.rgb), 32'b000);
        expect_eq("rst_step_a", 32'(bus_a.step), 0);
        expect_eq("rst_auto_a", 32'(bus_a.auto_mode), 0);
        rst = 1'b0;
        tick();
        expect_eq("post_rst_rgb_red", 32'(bus_a.rgb), 32'b011);
        expect_eq("post_rst_step", 32'(bus_a.step), 0);
        expect_eq("post_rst_auto", 32'(bus_a.auto_mode), 0);

        // Forward through the whole pattern; rgb lags step by one cycle
        for (int i = 0; i < 6; i++) begin
            pulse_a(1'b1, 1'b0, 1'b0);
            expect_eq($sformatf("fwd%0d_step", i), 32'(bus_a.step), 32'((i + 1) % 6));
            expect_eq($sformatf("fwd%0d_rgb", i), 32'(bus_a.rgb), 32'(lit_tab[i] ^ 3'b111));
        end
        pulse_a(1'b0, 1'b1, 1'b0);
        expect_eq("back_wrap_step", 32'(bus_a.step), 5);
        tick();
        expect_eq("back_wrap_rgb_magenta", 32'(bus_a.rgb), 32'b010);

        // Simultaneous fwd+back
        for (int i = 0; i < 3; i++) pulse_a(1'b1, 1'b0, 1'b0);
        expect_eq("reach_step2", 32'(bus_a.step), 2);
        pulse_a(1'b1, 1'b1, 1'b0);
        expect_eq("pair_at_2", 32'(bus_a.step), 2);
        pulse_a(1'b0, 1'b1, 1'b0);
        pulse_a(1'b0, 1'b1, 1'b0);
        expect_eq("reach_step0", 32'(bus_a.step), 0);
        pulse_a(1'b1, 1'b1, 1'b0);
        expect_eq("pair_at_0", 32'(bus_a.step), 0);

        // AUTO dwell timing
        pulse_a(1'b0, 1'b0, 1'b1);
        expect_eq("toggle_auto", 32'(bus_a.auto_mode), 1);
        expect_eq("toggle_keeps_step", 32'(bus_a.step), 0);
        wait_step_change(30, n);
        expect_eq("dwell1_cycles", 32'(n), 10);
        expect_eq("dwell1_step", 32'(bus_a.step), 1);
        wait_step_change(30, n);
        expect_eq("dwell2_cycles", 32'(n), 10);
        expect_eq("dwell2_step", 32'(bus_a.step), 2);
        for (int i = 0; i < 9; i++) tick();
        pulse_a(1'b1, 1'b0, 1'b0);
        expect_eq("fwd_on_expiry_step", 32'(bus_a.step), 3);
        wait_step_change(30, n);
        expect_eq("dwell_after_fwd_cycles", 32'(n), 10);
        expect_eq("dwell3_step", 32'(bus_a.step), 4);

        // Reset mid-dwell
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_eq("mid_rst_step", 32'(bus_a.step), 0);
        expect_eq("mid_rst_auto", 32'(bus_a.auto_mode), 0);
        expect_eq("mid_rst_rgb", 32'(bus_a.rgb), 32'b111);
        moves = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus_a.step != 3'd0 || bus_a.auto_mode) moves++;
        end
        expect_eq("no_auto_after_rst", 32'(moves), 0);

        // PWM on dut_b (active-high, period 7)
        bus_b.brightness = 3'd3;
        tick();
        count_b(14, n_red, n_dark);
        expect_eq("pwm3_lit", 32'(n_red), 6);
        expect_eq("pwm3_dark", 32'(n_dark), 8);
        bus_b.brightness = 3'd0;
        tick();
        count_b(14, n_red, n_dark);
        expect_eq("pwm0_dark", 32'(n_dark), 14);
        bus_b.brightness = 3'd7;
        tick();
        count_b(14, n_red, n_dark);
        expect_eq("pwm7_lit", 32'(n_red), 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
